// File: rtl/jelly2_video_pkg.sv
// Shared types for the video frame normalizer: FSM state encoding and
// the tuser bit that marks frame start.
package jelly2_video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAD_LINE,
    ST_SKIP_LINE,
    ST_PAD_FRAME
  } state_t;

  localparam int FS_BIT = 0;

endpackage

// File: rtl/jelly2_video_pixel_counter.sv
// x/y raster position counter. A load latches the frame size and restarts at
// (0,0); load and advance may coincide so the start pixel is counted immediately.
module jelly2_video_pixel_counter #(
  parameter int X_WIDTH = 14,
  parameter int Y_WIDTH = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cke,
  input  logic               load,
  input  logic               advance,
  input  logic [X_WIDTH-1:0] x_size,
  input  logic [Y_WIDTH-1:0] y_size,
  output logic               line_end,
  output logic               frame_end
);

  logic [X_WIDTH-1:0] xs_q, xs_d, x_q, x_d, x_base;
  logic [Y_WIDTH-1:0] ys_q, ys_d, y_q, y_d, y_base;

  always_comb begin
    xs_d   = load ? x_size : xs_q;
    ys_d   = load ? y_size : ys_q;
    x_base = load ? '0 : x_q;
    y_base = load ? '0 : y_q;
    x_d    = x_base;
    y_d    = y_base;
    if (advance) begin
      if (x_base == xs_d - X_WIDTH'(1)) begin
        x_d = '0;
        y_d = y_base + Y_WIDTH'(1);
      end else begin
        x_d = x_base + X_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xs_q <= '0;
      ys_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (cke) begin
      xs_q <= xs_d;
      ys_q <= ys_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign line_end  = (x_q == xs_q - X_WIDTH'(1));
  assign frame_end = line_end && (y_q == ys_q - Y_WIDTH'(1));

endmodule

// File: rtl/jelly2_video_frame_normalizer.sv
// Forces AXI4-Stream video into frames of exactly x_size x y_size beats:
// pads short lines/frames with param_fill, drops excess pixels, regenerates tuser/tlast.
//
// state        | meaning
// ST_IDLE      | waiting for an enabled frame start; other beats discarded
// ST_RUN       | passing input pixels through at (x,y)
// ST_PAD_LINE  | input line ended early; fill to end of line
// ST_SKIP_LINE | line full; discard input up to its tlast
// ST_PAD_FRAME | new frame start arrived early; fill to end of frame
module jelly2_video_frame_normalizer
  import jelly2_video_pkg::*;
#(
  parameter int                   TUSER_WIDTH = 1,
  parameter int                   TDATA_WIDTH = 24,
  parameter int                   X_WIDTH     = 14,
  parameter int                   Y_WIDTH     = 12,
  parameter logic [TDATA_WIDTH-1:0] INIT_FILL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic                   enable,
  output logic                   busy,
  input  logic [TDATA_WIDTH-1:0] param_fill,
  input  logic [X_WIDTH-1:0]     s_axi4s_x_size,
  input  logic [Y_WIDTH-1:0]     s_axi4s_y_size,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready
);

  state_t                 state_q, state_d;
  logic                   done_q, done_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
  logic [TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;

  logic                   load_en, s_fs, start_ok, s_ready_c;
  logic                   emit, emit_last, ctr_load, ctr_adv;
  logic                   px_accept, px_line_end, px_frame_end;
  logic [TDATA_WIDTH-1:0] emit_data;
  logic [TUSER_WIDTH-1:0] emit_user;
  logic                   line_end, frame_end;

  jelly2_video_pixel_counter #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .cke       (cke),
    .load      (ctr_load),
    .advance   (ctr_adv),
    .x_size    (s_axi4s_x_size),
    .y_size    (s_axi4s_y_size),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  assign load_en  = !m_tvalid_q || m_axi4s_tready;
  assign s_fs     = s_axi4s_tvalid && s_axi4s_tuser[FS_BIT];
  assign start_ok = s_fs && enable && (s_axi4s_x_size != '0) && (s_axi4s_y_size != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else if (cke) begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    s_ready_c    = 1'b0;
    emit         = 1'b0;
    emit_data    = param_fill;
    emit_user    = '0;
    emit_last    = 1'b0;
    ctr_load     = 1'b0;
    ctr_adv      = 1'b0;
    px_accept    = 1'b0;
    px_line_end  = line_end;
    px_frame_end = frame_end;
    unique case (state_q)
      ST_IDLE: begin
        // Only a frame start needs the output stage; everything else is dropped freely.
        s_ready_c = start_ok ? load_en : 1'b1;
        if (start_ok && load_en) begin
          px_accept         = 1'b1;
          ctr_load          = 1'b1;
          done_d            = 1'b0;
          px_line_end       = (s_axi4s_x_size == X_WIDTH'(1));
          px_frame_end      = px_line_end && (s_axi4s_y_size == Y_WIDTH'(1));
          emit_user         = s_axi4s_tuser;
          emit_user[FS_BIT] = 1'b1;
        end
      end
      ST_RUN: begin
        if (s_fs) begin
          state_d = ST_PAD_FRAME;
        end else begin
          s_ready_c = load_en;
          if (s_axi4s_tvalid && load_en) begin
            px_accept         = 1'b1;
            emit_user         = s_axi4s_tuser;
            emit_user[FS_BIT] = 1'b0;
          end
        end
      end
      ST_PAD_LINE: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_last = line_end;
          ctr_adv   = 1'b1;
          if (frame_end)     state_d = ST_IDLE;
          else if (line_end) state_d = ST_RUN;
        end
      end
      ST_SKIP_LINE: begin
        if (s_fs) begin
          state_d = done_q ? ST_IDLE : ST_PAD_FRAME;
        end else begin
          s_ready_c = 1'b1;
          if (s_axi4s_tvalid && s_axi4s_tlast) state_d = done_q ? ST_IDLE : ST_RUN;
        end
      end
      ST_PAD_FRAME: begin
        if (load_en) begin
          emit      = 1'b1;
          emit_last = line_end;
          ctr_adv   = 1'b1;
          if (frame_end) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (px_accept) begin
      emit      = 1'b1;
      emit_data = s_axi4s_tdata;
      emit_last = px_line_end;
      ctr_adv   = 1'b1;
      if (px_frame_end) begin
        if (s_axi4s_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SKIP_LINE;
          done_d  = 1'b1;
        end
      end else if (px_line_end) begin
        state_d = s_axi4s_tlast ? ST_RUN : ST_SKIP_LINE;
      end else begin
        state_d = s_axi4s_tlast ? ST_PAD_LINE : ST_RUN;
      end
    end
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    if (load_en) begin
      m_tvalid_d = emit;
      if (emit) begin
        m_tuser_d = emit_user;
        m_tlast_d = emit_last;
        m_tdata_d = emit_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else if (cke) begin
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

  assign s_axi4s_tready = s_ready_c && cke;
  assign busy           = (state_q != ST_IDLE);
  assign m_axi4s_tvalid = m_tvalid_q;
  assign m_axi4s_tuser  = m_tuser_q;
  assign m_axi4s_tlast  = m_tlast_q;
  assign m_axi4s_tdata  = m_tdata_q;

endmodule

// File: tb/tb_jelly2_video_frame_normalizer.sv
// Directed bench for the frame normalizer: output beats are collected into a
// queue and compared against hand-written expected frames.
module tb_jelly2_video_frame_normalizer;

  localparam logic [23:0] FILL = 24'hAAAAAA;

  logic        clk;
  logic        reset, cke, enable, busy;
  logic [23:0] param_fill;
  logic [13:0] s_x_size;
  logic [11:0] s_y_size;
  logic [0:0]  s_tuser, m_tuser;
  logic        s_tlast, s_tvalid, s_tready;
  logic [23:0] s_tdata, m_tdata;
  logic        m_tlast, m_tvalid, m_tready;

  int          n_chk = 0;
  int          n_fail = 0;
  int          stab_err = 0;
  logic        rand_rdy = 1'b0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_beat = '0;
  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];

  jelly2_video_frame_normalizer dut (
    .clk            (clk),
    .reset          (reset),
    .cke            (cke),
    .enable         (enable),
    .busy           (busy),
    .param_fill     (param_fill),
    .s_axi4s_x_size (s_x_size),
    .s_axi4s_y_size (s_y_size),
    .s_axi4s_tuser  (s_tuser),
    .s_axi4s_tlast  (s_tlast),
    .s_axi4s_tdata  (s_tdata),
    .s_axi4s_tvalid (s_tvalid),
    .s_axi4s_tready (s_tready),
    .m_axi4s_tuser  (m_tuser),
    .m_axi4s_tlast  (m_tlast),
    .m_axi4s_tdata  (m_tdata),
    .m_axi4s_tvalid (m_tvalid),
    .m_axi4s_tready (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor on the falling edge: collect handshakes, flag stalled beats that change.
  always @(negedge clk) begin
    if (prev_stall && !(m_tvalid && {m_tuser, m_tlast, m_tdata} === prev_beat))
      stab_err <= stab_err + 1;
    prev_stall <= m_tvalid && !m_tready;
    prev_beat  <= {m_tuser, m_tlast, m_tdata};
    if (m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
  end

  function automatic logic [25:0] pk(input logic [23:0] d, input logic u, input logic l);
    return {u, l, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [23:0] d, input logic u, input logic l);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      tick();
      n++;
    end
    s_tvalid = 1'b0;
    chk($sformatf("send_accept_%0h", d), 32'(acc), 32'd1);
  endtask

  task automatic check_out(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; cke = 1'b1; enable = 1'b1; param_fill = FILL;
    s_x_size = 14'd4; s_y_size = 12'd2;
    s_tuser = '0; s_tlast = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (3) tick();
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_m_tdata",  32'(m_tdata),  32'd0);
    chk("rst_m_tlast",  32'(m_tlast),  32'd0);
    chk("rst_m_tuser",  32'(m_tuser),  32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    reset = 1'b0;
    tick();

    // 1: clean 4x2 frame
    for (int i = 0; i < 8; i++) begin
      send(24'(32'h100 + i), i == 0, (i % 4) == 3);
      exp_q.push_back(pk(24'(32'h100 + i), i == 0, (i % 4) == 3));
    end
    repeat (3) tick();
    check_out("t1");
    chk("t1_busy_after", 32'(busy), 32'd0);

    // 2: short first line, size change mid-frame ignored
    send(24'h200, 1'b1, 1'b0);
    s_x_size = 14'd9;
    send(24'h201, 1'b0, 1'b1);
    for (int i = 2; i < 6; i++) send(24'(32'h200 + i), 1'b0, i == 5);
    s_x_size = 14'd4;
    repeat (3) tick();
    exp_q.push_back(pk(24'h200, 1'b1, 1'b0));
    exp_q.push_back(pk(24'h201, 1'b0, 1'b0));
    exp_q.push_back(pk(FILL,    1'b0, 1'b0));
    exp_q.push_back(pk(FILL,    1'b0, 1'b1));
    exp_q.push_back(pk(24'h202, 1'b0, 1'b0));
    exp_q.push_back(pk(24'h203, 1'b0, 1'b0));
    exp_q.push_back(pk(24'h204, 1'b0, 1'b0));
    exp_q.push_back(pk(24'h205, 1'b0, 1'b1));
    check_out("t2");

    // 3: over-long first line is truncated
    for (int i = 0; i < 6; i++) send(24'(32'h300 + i), i == 0, i == 5);
    for (int i = 6; i < 10; i++) send(24'(32'h300 + i), 1'b0, i == 9);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(pk(24'(32'h300 + i), i == 0, i == 3));
    for (int i = 6; i < 10; i++) exp_q.push_back(pk(24'(32'h300 + i), 1'b0, i == 9));
    check_out("t3");

    // 4: premature frame start after 5 beats
    for (int i = 0; i < 5; i++) send(24'(32'h400 + i), i == 0, i == 3);
    for (int i = 0; i < 8; i++) send(24'(32'h410 + i), i == 0, (i % 4) == 3);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(pk(24'(32'h400 + i), i == 0, i == 3));
    exp_q.push_back(pk(FILL, 1'b0, 1'b0));
    exp_q.push_back(pk(FILL, 1'b0, 1'b0));
    exp_q.push_back(pk(FILL, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++) exp_q.push_back(pk(24'(32'h410 + i), i == 0, (i % 4) == 3));
    check_out("t4");

    // 5: three 8x4 frames under random backpressure
    s_x_size = 14'd8; s_y_size = 12'd4;
    rand_rdy = 1'b1;
    for (int i = 0; i < 96; i++) begin
      send(24'(32'h500 + i), (i % 32) == 0, (i % 8) == 7);
      exp_q.push_back(pk(24'(32'h500 + i), (i % 32) == 0, (i % 8) == 7));
    end
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    repeat (5) tick();
    check_out("t5");
    chk("t5_stall_stable", 32'(stab_err), 32'd0);

    // 6: disabled frame discarded, then reset in mid-RUN
    s_x_size = 14'd4; s_y_size = 12'd2;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) send(24'(32'h600 + i), i == 0, (i % 4) == 3);
    chk("t6_busy_disabled", 32'(busy), 32'd0);
    repeat (3) tick();
    check_out("t6_disabled");
    enable = 1'b1;
    for (int i = 0; i < 3; i++) send(24'(32'h610 + i), i == 0, 1'b0);
    chk("t6_busy_run", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_rst_busy",     32'(busy),     32'd0);
    reset = 1'b0;
    tick();
    got_q.delete();

    // cke freeze while a 2x1 frame is in flight
    s_x_size = 14'd2; s_y_size = 12'd1;
    send(24'h700, 1'b1, 1'b0);
    m_tready = 1'b0;
    cke = 1'b0;
    s_tvalid = 1'b1; s_tdata = 24'h701; s_tuser = '0; s_tlast = 1'b1;
    tick();
    tick();
    chk("cke_s_tready", 32'(s_tready), 32'd0);
    chk("cke_m_tvalid", 32'(m_tvalid), 32'd1);
    chk("cke_m_tdata",  32'(m_tdata),  32'h700);
    chk("cke_busy",     32'(busy),     32'd1);
    cke = 1'b1;
    m_tready = 1'b1;
    send(24'h701, 1'b0, 1'b1);
    repeat (3) tick();
    exp_q.push_back(pk(24'h700, 1'b1, 1'b0));
    exp_q.push_back(pk(24'h701, 1'b0, 1'b1));
    check_out("cke");
    chk("cke_busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
